vga_board_capture: RTL and testbench

- Receive-side counterpart of the board display path: consumes the 8-bit tiny-vga pin bus and recovers hpos/vpos from the sync edges.
- Samples the centre pixel of each of the 8x8 cells and reconstructs the 64-bit Game of Life board once per frame.
- Used as an on-chip/bench monitor to check displayed generations and detect sync faults.

---
 rtl/vga_capture_pkg.sv | 32 +++
 rtl/vga_board_capture_if.sv | 24 ++
 rtl/vga_sync_recover.sv | 103 ++++++++++
 rtl/vga_board_capture.sv | 115 +++++++++++
 tb/tb_vga_board_capture.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/vga_capture_pkg.sv
// Shared timing constants, board geometry and lock-state encoding for the VGA
// board capture path.
package vga_capture_pkg;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_TOTAL      = 10'd525;
    localparam logic [9:0] CELL_SIZE    = 10'd48;
    localparam logic [9:0] BOARD_X0     = 10'd128;
    localparam logic [9:0] BOARD_Y0     = 10'd48;

    localparam int unsigned BOARD_W    = 8;
    localparam int unsigned BOARD_H    = 8;
    localparam int unsigned BOARD_BITS = BOARD_W * BOARD_H;

    typedef enum logic [1:0] {
        SEARCH,
        H_LOCK,
        LOCKED
    } capture_state_t;

    // Pixel coordinate of the centre of cell number idx along one axis.
    function automatic logic [9:0] cell_centre(input logic [9:0] origin,
                                               input logic [9:0] size,
                                               input int unsigned idx);
        return origin + 10'(idx) * size + (size >> 1);
    endfunction

endpackage

// File: rtl/vga_board_capture_if.sv
// Pin bus into the capture block plus the recovered board and status signals.
interface vga_board_capture_if;
    import vga_capture_pkg::*;

    logic [7:0]            vga_in;
    logic [BOARD_BITS-1:0] board;
    logic                  board_valid;
    logic                  board_changed;
    logic [7:0]            frame_count;
    logic                  locked;
    logic                  sync_error;

    // master: the display source / observer; slave: the capture block.
    modport master (
        output vga_in,
        input  board, board_valid, board_changed, frame_count, locked, sync_error
    );

    modport slave (
        input  vga_in,
        output board, board_valid, board_changed, frame_count, locked, sync_error
    );

endinterface

// File: rtl/vga_sync_recover.sv
// Registers the tiny-vga pin bus, detects sync falls and recovers hpos/vpos
// through a SEARCH -> H_LOCK -> LOCKED state machine.
module vga_sync_recover
    import vga_capture_pkg::*;
#(
    parameter logic [9:0] H_SYNC_START = vga_capture_pkg::H_SYNC_START,
    parameter logic [9:0] H_TOTAL      = vga_capture_pkg::H_TOTAL,
    parameter logic [9:0] V_SYNC_START = vga_capture_pkg::V_SYNC_START,
    parameter logic [9:0] V_TOTAL      = vga_capture_pkg::V_TOTAL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] vga_in,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic [5:0] pixel,
    output logic       locked,
    output logic       frame_ok,
    output logic       sync_error
);

    capture_state_t state;
    logic [7:0]     vga_q;
    logic           hsync_d;
    logic           vsync_d;
    logic           hsync_fall;
    logic           vsync_fall;
    logic           h_err;
    logic           v_err;
    logic           line_end;
    logic           frame_end;

    assign hsync_fall = hsync_d & ~vga_q[7];
    assign vsync_fall = vsync_d & ~vga_q[3];
    assign h_err      = hsync_fall && (hcnt != H_SYNC_START);
    assign v_err      = vsync_fall && (vcnt != V_SYNC_START);
    assign line_end   = (hcnt == H_TOTAL - 10'd1);
    assign frame_end  = (vcnt == V_TOTAL - 10'd1);
    assign pixel      = {vga_q[6:4], vga_q[2:0]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_q      <= '0;
            hsync_d    <= 1'b0;
            vsync_d    <= 1'b0;
            hcnt       <= '0;
            vcnt       <= '0;
            state      <= SEARCH;
            locked     <= 1'b0;
            frame_ok   <= 1'b0;
            sync_error <= 1'b0;
        end else begin
            vga_q      <= vga_in;
            hsync_d    <= vga_q[7];
            vsync_d    <= vga_q[3];
            sync_error <= 1'b0;

            if (line_end) begin
                hcnt <= '0;
                vcnt <= frame_end ? '0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end

            unique case (state)
                SEARCH: begin
                    if (hsync_fall) begin
                        hcnt  <= H_SYNC_START + 10'd1;
                        state <= H_LOCK;
                    end
                end
                H_LOCK: begin
                    // Resync on every hsync fall; a correct one reloads the same value.
                    if (hsync_fall) hcnt <= H_SYNC_START + 10'd1;
                    if (vsync_fall) begin
                        vcnt   <= V_SYNC_START;
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (h_err || v_err) begin
                        sync_error <= 1'b1;
                        state      <= H_LOCK;
                        locked     <= 1'b0;
                        frame_ok   <= 1'b0;
                        if (h_err) hcnt <= H_SYNC_START + 10'd1;
                    end else if (line_end && frame_end) begin
                        // Next frame starts at line 0 while locked: it may be committed.
                        frame_ok <= 1'b1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/vga_board_capture.sv
// Samples the centre pixel of each board cell from the recovered raster and
// commits the reconstructed Game of Life board once per clean frame.
module vga_board_capture
    import vga_capture_pkg::*;
#(
    parameter logic [9:0] H_VISIBLE    = vga_capture_pkg::H_VISIBLE,
    parameter logic [9:0] H_SYNC_START = vga_capture_pkg::H_SYNC_START,
    parameter logic [9:0] H_TOTAL      = vga_capture_pkg::H_TOTAL,
    parameter logic [9:0] V_VISIBLE    = vga_capture_pkg::V_VISIBLE,
    parameter logic [9:0] V_SYNC_START = vga_capture_pkg::V_SYNC_START,
    parameter logic [9:0] V_TOTAL      = vga_capture_pkg::V_TOTAL,
    parameter logic [9:0] CELL_SIZE    = vga_capture_pkg::CELL_SIZE,
    parameter logic [9:0] BOARD_X0     = vga_capture_pkg::BOARD_X0,
    parameter logic [9:0] BOARD_Y0     = vga_capture_pkg::BOARD_Y0
) (
    input logic                clk,
    input logic                rst_n,
    vga_board_capture_if.slave cap
);

    logic [9:0]            hcnt;
    logic [9:0]            vcnt;
    logic [5:0]            pixel;
    logic                  locked;
    logic                  frame_ok;
    logic                  sync_error;

    logic                  col_hit;
    logic                  row_hit;
    logic [2:0]            col_idx;
    logic [2:0]            row_idx;
    logic                  sample_en;
    logic                  commit;

    logic [BOARD_BITS-1:0] shadow;
    logic [BOARD_BITS-1:0] board_q;
    logic                  board_valid_q;
    logic                  board_changed_q;
    logic [7:0]            frame_count_q;

    vga_sync_recover #(
        .H_SYNC_START (H_SYNC_START),
        .H_TOTAL      (H_TOTAL),
        .V_SYNC_START (V_SYNC_START),
        .V_TOTAL      (V_TOTAL)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_in     (cap.vga_in),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .pixel      (pixel),
        .locked     (locked),
        .frame_ok   (frame_ok),
        .sync_error (sync_error)
    );

    // NOTE: every always_comb output is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        col_hit = 1'b0;
        row_hit = 1'b0;
        col_idx = '0;
        row_idx = '0;
        for (int unsigned i = 0; i < BOARD_W; i++) begin
            if (hcnt == cell_centre(BOARD_X0, CELL_SIZE, i)) begin
                col_hit = 1'b1;
                col_idx = 3'(i);
            end
        end
        for (int unsigned i = 0; i < BOARD_H; i++) begin
            if (vcnt == cell_centre(BOARD_Y0, CELL_SIZE, i)) begin
                row_hit = 1'b1;
                row_idx = 3'(i);
            end
        end
    end

    assign sample_en = locked && col_hit && row_hit
                    && (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE);
    assign commit    = locked && frame_ok && (vcnt == V_VISIBLE) && (hcnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow board is reset too, so the first commit after
            // reset never exposes stale cells from before the reset.
            shadow          <= '0;
            board_q         <= '0;
            board_valid_q   <= 1'b0;
            board_changed_q <= 1'b0;
            frame_count_q   <= '0;
        end else begin
            board_valid_q   <= 1'b0;
            board_changed_q <= 1'b0;

            // A cell is alive only when its centre pixel is fully black.
            if (sample_en) shadow[{row_idx, col_idx}] <= (pixel == 6'd0);

            if (commit) begin
                board_q         <= shadow;
                board_valid_q   <= 1'b1;
                board_changed_q <= (shadow != board_q);
                frame_count_q   <= frame_count_q + 8'd1;
            end
        end
    end

    assign cap.board         = board_q;
    assign cap.board_valid   = board_valid_q;
    assign cap.board_changed = board_changed_q;
    assign cap.frame_count   = frame_count_q;
    assign cap.locked        = locked;
    assign cap.sync_error    = sync_error;

endmodule

// File: tb/tb_vga_board_capture.sv
// Scoreboard bench for vga_board_capture on a scaled-down raster: expected
// commits are queued per frame and matched against each board_valid pulse.
module tb_vga_board_capture;

    localparam int HV  = 48;
    localparam int HSS = 52;
    localparam int HT  = 64;
    localparam int VV  = 40;
    localparam int VSS = 42;
    localparam int VT  = 46;
    localparam int CS  = 4;
    localparam int X0  = 8;
    localparam int Y0  = 4;

    localparam logic [63:0] BLINK_A = 64'h0000_0008_0808_0000;  // bits 19,27,35
    localparam logic [63:0] BLINK_B = 64'h0000_0000_1C00_0000;  // bits 26,27,28
    localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;  // bits 1,10,16,17,18

    typedef struct packed {
        logic [63:0] board;
        logic        changed;
        logic [7:0]  count;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_board_capture_if cap();

    vga_board_capture #(
        .H_VISIBLE    (10'(HV)),
        .H_SYNC_START (10'(HSS)),
        .H_TOTAL      (10'(HT)),
        .V_VISIBLE    (10'(VV)),
        .V_SYNC_START (10'(VSS)),
        .V_TOTAL      (10'(VT)),
        .CELL_SIZE    (10'(CS)),
        .BOARD_X0     (10'(X0)),
        .BOARD_Y0     (10'(Y0))
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cap   (cap)
    );

    int          checks     = 0;
    int          errors     = 0;
    int          err_pulses = 0;
    exp_t        exp_q[$];
    logic [63:0] prev_board   = '0;
    logic [7:0]  model_count  = '0;
    logic        model_locked = 1'b0;
    int          early_line = -1;
    int          rst_line   = -1;
    int          blk_h      = -1;
    int          blk_v      = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference raster: alive cells fill their whole square black, other
    // visible pixels white, blanking black; syncs active-low.
    function automatic logic [7:0] pix(input int h, input int v, input logic [63:0] pat);
        logic       hs;
        logic       vs;
        logic [2:0] c;
        hs = !(h >= HSS && h < HSS + 8);
        if (v == early_line && h >= HSS - 4 && h < HSS) hs = 1'b0;
        vs = !(v >= VSS && v < VSS + 2);
        c  = 3'b000;
        if (h < HV && v < VV) begin
            c = 3'b111;
            if (h >= X0 && h < X0 + 8 * CS && v >= Y0 && v < Y0 + 8 * CS)
                if (pat[((v - Y0) / CS) * 8 + (h - X0) / CS]) c = 3'b000;
            if (h == blk_h && v == blk_v) c = 3'b000;
        end
        return {hs, c, vs, c};
    endfunction

    task automatic drive_frame(input logic [63:0] pat, input logic [63:0] exp_board,
                               input logic disturb);
        exp_t e;
        if (model_locked && !disturb) begin
            model_count++;
            e.board   = exp_board;
            e.changed = (exp_board != prev_board);
            e.count   = model_count;
            prev_board = exp_board;
            exp_q.push_back(e);
        end
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                @(posedge clk);
                #1;
                cap.vga_in = pix(h, v, pat);
                if (v == rst_line && h == 0) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_board", cap.board, 64'd0);
                    check("rst_locked", {63'd0, cap.locked}, 64'd0);
                    check("rst_frame_count", {56'd0, cap.frame_count}, 64'd0);
                    prev_board   = '0;
                    model_count  = '0;
                    model_locked = 1'b0;
                end
                if (v == rst_line && h == 4) rst_n = 1'b1;
                if (early_line >= 0 && v == early_line + 1 && h == 0)
                    check("locked_after_glitch", {63'd0, cap.locked}, 64'd0);
                if (v == VSS + 1 && h == 2)
                    check("locked", {63'd0, cap.locked}, 64'd1);
            end
        end
        model_locked = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (cap.sync_error) err_pulses++;
            if (cap.board_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("board", cap.board, e.board);
                    check("board_changed", {63'd0, cap.board_changed}, {63'd0, e.changed});
                    check("frame_count", {56'd0, cap.frame_count}, {56'd0, e.count});
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $fatal(1);
    end

    initial begin : stimulus
        cap.vga_in = 8'h88;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_board", cap.board, 64'd0);
        check("reset_valid", {63'd0, cap.board_valid}, 64'd0);
        check("reset_changed", {63'd0, cap.board_changed}, 64'd0);
        check("reset_frame_count", {56'd0, cap.frame_count}, 64'd0);
        check("reset_locked", {63'd0, cap.locked}, 64'd0);
        check("reset_sync_error", {63'd0, cap.sync_error}, 64'd0);
        rst_n = 1'b1;

        // Nominal white frames: first one only acquires lock.
        repeat (3) drive_frame('0, '0, 1'b0);

        // Blinker oscillation, then a static glider.
        drive_frame(BLINK_A, BLINK_A, 1'b0);
        drive_frame(BLINK_B, BLINK_B, 1'b0);
        drive_frame(BLINK_A, BLINK_A, 1'b0);
        drive_frame(GLIDER, GLIDER, 1'b0);
        drive_frame(GLIDER, GLIDER, 1'b0);

        // One hsync fall four pixels early mid-frame.
        early_line = 20;
        drive_frame(GLIDER, GLIDER, 1'b1);
        early_line = -1;
        check("sync_error_pulses", 64'(err_pulses), 64'd1);
        drive_frame(BLINK_A, BLINK_A, 1'b0);

        // Only the exact centre pixel of cell (7,7) decides its state.
        blk_h = X0 + 7 * CS + CS / 2;
        blk_v = Y0 + 7 * CS + CS / 2;
        drive_frame('0, 64'h8000_0000_0000_0000, 1'b0);
        blk_h = X0 + 7 * CS + CS / 2 - 1;
        drive_frame('0, '0, 1'b0);
        blk_h = -1;
        blk_v = -1;

        // Reset mid-frame, then relock and commit from scratch.
        rst_line = 20;
        drive_frame(BLINK_A, BLINK_A, 1'b1);
        rst_line = -1;
        repeat (2) drive_frame('0, '0, 1'b0);

        repeat (10) @(posedge clk);
        #1;
        check("missing_commits", 64'(exp_q.size()), 64'd0);
        check("sync_error_total", 64'(err_pulses), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
